// File: rtl/alu_wb_buffer_pkg.sv
// Shared types and constants for the ALU writeback buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_wb_buffer_pkg;

  localparam int SIZE_DATA           = 32;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_ACTIVELIST_LOG = 7;
  localparam int EXECUTION_FLAGS     = 6;

  // Bit positions inside the ALU flag vector
  localparam int FLAG_DEST_WR    = 4;
  localparam int FLAG_EXECUTED   = 2;
  localparam int FLAG_EXCEPTION  = 1;
  localparam int FLAG_MISPREDICT = 0;

  // One buffered ALU completion
  typedef struct packed {
    logic [SIZE_DATA-1:0]           result;
    logic [EXECUTION_FLAGS-1:0]     flags;
    logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest;
    logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo_core.sv
// Generic DEPTH-entry circular buffer with push, pop, flush and occupancy count.
// Latency: a pushed entry reaches head_o the cycle after the push (no flow-through).
// Backpressure: caller must not push when full nor pop when empty; flush wins over both.
module alu_wb_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state pointers and count; DEPTH is a power of two so pointers wrap on overflow
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; left uninitialised by reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= din_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_wb_buffer.sv
// Skid buffer between the ALU and the shared writeback bus, plus completion packet register.
// Latency: push in cycle N is visible on wb_valid_o at N+1; a pop in cycle M gives ctrl_valid_o at M+1.
// Backpressure: in_ready_o comes from registered count only; dest-writing heads wait for wb_grant_i, NOPs auto-pop.
module alu_wb_buffer
  import alu_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recover_flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [SIZE_DATA-1:0]           result_i,
  input  logic [EXECUTION_FLAGS-1:0]     flags_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] al_id_i,
  output logic                           wb_valid_o,
  input  logic                           wb_grant_i,
  output logic [SIZE_DATA-1:0]           wb_data_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]   wb_tag_o,
  output logic                           ctrl_valid_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] ctrl_al_id_o,
  output logic [EXECUTION_FLAGS-1:0]     ctrl_flags_o,
  output logic [CNT_W-1:0]               occupancy_o
);

  wb_entry_t              in_entry;
  wb_entry_t              head_entry;
  logic [$bits(wb_entry_t)-1:0] head_raw;
  logic [CNT_W-1:0]       count;
  logic                   non_empty;
  logic                   head_dest;
  logic                   push;
  logic                   pop;

  logic                           ctrl_valid_q, ctrl_valid_d;
  logic [SIZE_ACTIVELIST_LOG-1:0] ctrl_al_id_q, ctrl_al_id_d;
  logic [EXECUTION_FLAGS-1:0]     ctrl_flags_q, ctrl_flags_d;

  assign in_entry = '{result: result_i, flags: flags_i, phy_dest: phy_dest_i, al_id: al_id_i};
  assign head_entry = wb_entry_t'(head_raw);

  alu_wb_fifo_core #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (recover_flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_entry),
    .head_o  (head_raw),
    .count_o (count)
  );

  // Accept/pop decisions: NOP heads leave on their own, dest heads need the bus; flush kills both
  always_comb begin
    in_ready_o = (count != CNT_W'(DEPTH));
    non_empty  = (count != '0);
    head_dest  = head_entry.flags[FLAG_DEST_WR];
    push       = in_valid_i & in_ready_o & ~recover_flush_i;
    pop        = non_empty & (head_dest ? wb_grant_i : 1'b1) & ~recover_flush_i;
  end

  // Writeback request side; data forced to zero when empty so outputs read 0 after reset
  always_comb begin
    wb_valid_o  = non_empty & head_dest;
    wb_data_o   = non_empty ? head_entry.result   : '0;
    wb_tag_o    = non_empty ? head_entry.phy_dest : '0;
    occupancy_o = count;
  end

  // Completion packet next state: captures the entry leaving the head
  always_comb begin
    ctrl_valid_d = pop;
    ctrl_al_id_d = ctrl_al_id_q;
    ctrl_flags_d = ctrl_flags_q;
    if (pop) begin
      ctrl_al_id_d = head_entry.al_id;
      ctrl_flags_d = head_entry.flags;
    end
  end

  // Completion packet register
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_valid_q <= 1'b0;
      ctrl_al_id_q <= '0;
      ctrl_flags_q <= '0;
    end else begin
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_al_id_q <= ctrl_al_id_d;
      ctrl_flags_q <= ctrl_flags_d;
    end
  end

  assign ctrl_valid_o = ctrl_valid_q;
  assign ctrl_al_id_o = ctrl_al_id_q;
  assign ctrl_flags_o = ctrl_flags_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Bench for alu_wb_buffer: queue-based model checked every cycle plus directed literal checks.
// Latency: model expects one-cycle visibility after push and one-cycle completion after pop.
// Backpressure: stimulus never pushes into a full buffer except when flushing.
module tb_alu_wb_buffer;
  import alu_wb_buffer_pkg::*;

  localparam int DEPTH = 2;

  logic                           clk;
  logic                           reset;
  logic                           recover_flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [SIZE_DATA-1:0]           result;
  logic [EXECUTION_FLAGS-1:0]     flags;
  logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest;
  logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
  logic                           wb_valid;
  logic                           wb_grant;
  logic [SIZE_DATA-1:0]           wb_data;
  logic [SIZE_PHYSICAL_LOG-1:0]   wb_tag;
  logic                           ctrl_valid;
  logic [SIZE_ACTIVELIST_LOG-1:0] ctrl_al_id;
  logic [EXECUTION_FLAGS-1:0]     ctrl_flags;
  logic [1:0]                     occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  alu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .recover_flush_i (recover_flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .result_i        (result),
    .flags_i         (flags),
    .phy_dest_i      (phy_dest),
    .al_id_i         (al_id),
    .wb_valid_o      (wb_valid),
    .wb_grant_i      (wb_grant),
    .wb_data_o       (wb_data),
    .wb_tag_o        (wb_tag),
    .ctrl_valid_o    (ctrl_valid),
    .ctrl_al_id_o    (ctrl_al_id),
    .ctrl_flags_o    (ctrl_flags),
    .occupancy_o     (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  wb_entry_t                      mq[$];
  bit                             m_ctrl_vld;
  logic [SIZE_ACTIVELIST_LOG-1:0] m_ctrl_al;
  logic [EXECUTION_FLAGS-1:0]     m_ctrl_fl;
  bit                             m_pop;
  bit                             m_push;
  wb_entry_t                      m_in;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ctrl_vld = 0;
    end else begin
      if (in_valid && !recover_flush && mq.size() == DEPTH) begin
        errors++;
        $display("FAIL protocol: in_valid while full, occupancy %0d", mq.size());
      end
      m_pop  = 0;
      if (mq.size() > 0 && !recover_flush)
        m_pop = mq[0].flags[FLAG_DEST_WR] ? wb_grant : 1'b1;
      m_push = in_valid && !recover_flush && (mq.size() < DEPTH);
      m_in   = '{result: result, flags: flags, phy_dest: phy_dest, al_id: al_id};
      if (recover_flush) begin
        mq.delete();
        m_ctrl_vld = 0;
      end else begin
        m_ctrl_vld = m_pop;
        if (m_pop) begin
          m_ctrl_al = mq[0].al_id;
          m_ctrl_fl = mq[0].flags;
          void'(mq.pop_front());
        end
        if (m_push) mq.push_back(m_in);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_wbv;
      exp_wbv = (mq.size() > 0) && mq[0].flags[FLAG_DEST_WR];
      check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("m_occupancy", 32'(occupancy), 32'(mq.size()));
      check("m_wb_valid", 32'(wb_valid), 32'(exp_wbv));
      if (exp_wbv) begin
        check("m_wb_data", wb_data, mq[0].result);
        check("m_wb_tag", 32'(wb_tag), 32'(mq[0].phy_dest));
      end
      check("m_ctrl_valid", 32'(ctrl_valid), 32'(m_ctrl_vld));
      if (m_ctrl_vld) begin
        check("m_ctrl_al_id", 32'(ctrl_al_id), 32'(m_ctrl_al));
        check("m_ctrl_flags", 32'(ctrl_flags), 32'(m_ctrl_fl));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [5:0] f,
                       input logic [6:0] t, input logic [6:0] a);
    in_valid = v;
    result   = r;
    flags    = f;
    phy_dest = t;
    al_id    = a;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 6'h0, 7'h0, 7'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    recover_flush = 1'b0;
    wb_grant = 1'b0;
    idle();
    tick();
    // Reset state
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_ctrl_valid", 32'(ctrl_valid), 0);
    check("rst_ctrl_al", 32'(ctrl_al_id), 0);
    check("rst_ctrl_flags", 32'(ctrl_flags), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_in_ready", 32'(in_ready), 1);
    chk_en = 1;
    reset = 1'b0;
    tick();

    // Single ADD with grant held high
    wb_grant = 1'b1;
    drive(1'b1, 32'h0000_0005, 6'h14, 7'd9, 7'd3);
    tick();
    idle();
    check("add_wb_valid", 32'(wb_valid), 1);
    check("add_wb_data", wb_data, 32'h5);
    check("add_wb_tag", 32'(wb_tag), 9);
    check("add_ctrl_early", 32'(ctrl_valid), 0);
    tick();
    check("add_ctrl_valid", 32'(ctrl_valid), 1);
    check("add_ctrl_al", 32'(ctrl_al_id), 3);
    check("add_ctrl_flags", 32'(ctrl_flags), 32'h14);
    check("add_occupancy", 32'(occupancy), 0);
    tick();

    // Backpressure: two pushes fill the buffer, third waits
    wb_grant = 1'b0;
    drive(1'b1, 32'h100, 6'h14, 7'd1, 7'd0);
    tick();
    drive(1'b1, 32'h101, 6'h14, 7'd2, 7'd1);
    tick();
    idle();
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_occupancy", 32'(occupancy), 2);
    check("bp_head_data", wb_data, 32'h100);
    tick();
    tick();
    wb_grant = 1'b1;
    tick();
    check("bp_drain0_al", 32'(ctrl_al_id), 0);
    check("bp_drain0_vld", 32'(ctrl_valid), 1);
    drive(1'b1, 32'h102, 6'h14, 7'd3, 7'd2);
    tick();
    idle();
    check("bp_drain1_al", 32'(ctrl_al_id), 1);
    check("bp_drain1_occ", 32'(occupancy), 1);
    tick();
    check("bp_drain2_al", 32'(ctrl_al_id), 2);
    check("bp_drain2_occ", 32'(occupancy), 0);
    tick();

    // NOP auto-pop without grant
    wb_grant = 1'b0;
    drive(1'b1, 32'hDEAD, 6'h04, 7'd11, 7'd5);
    tick();
    idle();
    check("nop_wb_valid", 32'(wb_valid), 0);
    check("nop_ctrl_early", 32'(ctrl_valid), 0);
    tick();
    check("nop_ctrl_valid", 32'(ctrl_valid), 1);
    check("nop_ctrl_flags", 32'(ctrl_flags), 32'h04);
    check("nop_ctrl_al", 32'(ctrl_al_id), 5);
    tick();

    // Mixed head: NOP then ADD, grant low
    drive(1'b1, 32'h1111, 6'h04, 7'd12, 7'd6);
    tick();
    drive(1'b1, 32'hABCD, 6'h14, 7'h22, 7'd7);
    tick();
    idle();
    check("mix_nop_done", 32'(ctrl_al_id), 6);
    check("mix_wb_valid", 32'(wb_valid), 1);
    check("mix_wb_data", wb_data, 32'hABCD);
    tick();
    check("mix_hold_ctrl", 32'(ctrl_valid), 0);
    tick();
    wb_grant = 1'b1;
    tick();
    check("mix_add_al", 32'(ctrl_al_id), 7);
    check("mix_add_flags", 32'(ctrl_flags), 32'h14);
    tick();

    // Flush with full buffer, incoming push and grant in the same cycle
    wb_grant = 1'b0;
    drive(1'b1, 32'hA0, 6'h14, 7'd20, 7'd10);
    tick();
    drive(1'b1, 32'hA1, 6'h14, 7'd21, 7'd11);
    tick();
    check("fl_full", 32'(occupancy), 2);
    drive(1'b1, 32'hA2, 6'h14, 7'd22, 7'd12);
    wb_grant = 1'b1;
    recover_flush = 1'b1;
    tick();
    recover_flush = 1'b0;
    idle();
    check("fl_occupancy", 32'(occupancy), 0);
    check("fl_ctrl_valid", 32'(ctrl_valid), 0);
    check("fl_wb_valid", 32'(wb_valid), 0);
    tick();
    check("fl_no_ghost", 32'(ctrl_valid), 0);
    tick();

    // Reset mid-drain with two entries buffered
    wb_grant = 1'b0;
    drive(1'b1, 32'hB0, 6'h14, 7'd30, 7'd20);
    tick();
    drive(1'b1, 32'hB1, 6'h14, 7'd31, 7'd21);
    tick();
    idle();
    wb_grant = 1'b1;
    tick();
    reset = 1'b1;
    recover_flush = 1'b1;
    tick();
    reset = 1'b0;
    recover_flush = 1'b0;
    wb_grant = 1'b0;
    check("mr_wb_valid", 32'(wb_valid), 0);
    check("mr_ctrl_valid", 32'(ctrl_valid), 0);
    check("mr_ctrl_al", 32'(ctrl_al_id), 0);
    check("mr_occupancy", 32'(occupancy), 0);
    check("mr_wb_tag", 32'(wb_tag), 0);
    drive(1'b1, 32'h77, 6'h14, 7'd3, 7'd22);
    tick();
    idle();
    check("post_rst_data", wb_data, 32'h77);
    check("post_rst_tag", 32'(wb_tag), 3);
    wb_grant = 1'b1;
    tick();
    check("post_rst_ctrl_al", 32'(ctrl_al_id), 22);
    check("post_rst_ctrl_vld", 32'(ctrl_valid), 1);
    wb_grant = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
